isdu_waitstate: RTL

- Next-generation SLC-3 instruction sequencer/decoder: a Moore FSM that drives every datapath load, gate, mux-select and SRAM strobe.
- Extends the fetch/ADD/AND/NOT control set with BR, JMP, JSR, LDR, STR and PAUSE.
- Memory access latency is parametrised, so the datapath can run against slower SRAM.
- Sits between the datapath (IR opcode, BEN) and the board SRAM/LED interface.

---
 rtl/isdu_waitstate.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/isdu_waitstate.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : isdu_waitstate
//  Brief    : SLC-3 instruction sequencer/decoder (Moore FSM) with
//             parametrised SRAM wait states and optional fetch pause.
//  Revision : 1.0 - initial release
// ============================================================================
module isdu_waitstate #(
    parameter int MEM_WAIT    = 1,
    parameter int PAUSE_FETCH = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic       ContinueIR,
    input  logic       BEN,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE_n,
    output logic       Mem_WE_n
);

    localparam int              c_wc_w      = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [c_wc_w-1:0] c_wait_last = c_wc_w'(MEM_WAIT);

    typedef enum logic [4:0] {
        HALTED    = 5'd0,
        S18       = 5'd1,
        S33       = 5'd2,
        S35       = 5'd3,
        PAUSE_IR1 = 5'd4,
        PAUSE_IR2 = 5'd5,
        S32       = 5'd6,
        S01       = 5'd7,
        S05       = 5'd8,
        S09       = 5'd9,
        S00       = 5'd10,
        S22       = 5'd11,
        S12       = 5'd12,
        S04       = 5'd13,
        S21       = 5'd14,
        S06       = 5'd15,
        S25       = 5'd16,
        S27       = 5'd17,
        S07       = 5'd18,
        S23       = 5'd19,
        S16       = 5'd20,
        S13       = 5'd21,
        PAUSE1    = 5'd22,
        PAUSE2    = 5'd23
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_wc_w-1:0]   r_wc;
    logic                w_mem_state;
    logic                w_wait_done;

    assign w_mem_state = (r_state == S33) || (r_state == S25) || (r_state == S16);
    assign w_wait_done = (r_wc == c_wait_last);

    // Memory states are only ever entered from and left to non-memory states,
    // so clearing whenever the count is not advancing gives a fresh count on entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= HALTED;
            r_wc    <= '0;
        end else begin
            r_state <= w_next;
            if (w_mem_state && !w_wait_done)
                r_wc <= r_wc + 1'b1;
            else
                r_wc <= '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        MIO_EN     = 1'b0;
        Mem_OE_n   = 1'b1;
        Mem_WE_n   = 1'b1;

        case (r_state)
            HALTED: begin
                if (Run)
                    w_next = S18;
            end
            S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                w_next = S33;
            end
            S33, S25: begin
                Mem_OE_n = 1'b0;
                if (w_wait_done) begin
                    LD_MDR = 1'b1;
                    MIO_EN = 1'b1;
                    w_next = (r_state == S33) ? S35 : S27;
                end
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                w_next  = (PAUSE_FETCH != 0) ? PAUSE_IR1 : S32;
            end
            PAUSE_IR1: begin
                if (ContinueIR)
                    w_next = PAUSE_IR2;
            end
            PAUSE_IR2: begin
                if (!ContinueIR)
                    w_next = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: w_next = S01;
                    4'b0101: w_next = S05;
                    4'b1001: w_next = S09;
                    4'b0000: w_next = S00;
                    4'b1100: w_next = S12;
                    4'b0100: w_next = S04;
                    4'b0110: w_next = S06;
                    4'b0111: w_next = S07;
                    4'b1101: w_next = S13;
                    default: w_next = S18;
                endcase
            end
            S01, S05, S09: begin
                SR1MUX  = 1'b1;
                SR2MUX  = (r_state == S09) ? 1'b0 : IR_5;
                ALUK    = (r_state == S01) ? 2'b00 : ((r_state == S05) ? 2'b01 : 2'b10);
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                w_next  = S18;
            end
            S00: begin
                w_next = BEN ? S22 : S18;
            end
            S22: begin
                PCMUX    = 2'b10;
                ADDR2MUX = 2'b10;
                LD_PC    = 1'b1;
                w_next   = S18;
            end
            S12: begin
                PCMUX    = 2'b10;
                ADDR1MUX = 1'b1;
                SR1MUX   = 1'b1;
                LD_PC    = 1'b1;
                w_next   = S18;
            end
            S04: begin
                DRMUX  = 1'b1;
                GatePC = 1'b1;
                LD_REG = 1'b1;
                w_next = S21;
            end
            S21: begin
                PCMUX    = 2'b10;
                ADDR2MUX = 2'b11;
                LD_PC    = 1'b1;
                w_next   = S18;
            end
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                w_next     = (r_state == S06) ? S25 : S23;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                w_next  = S18;
            end
            S23: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                w_next  = S16;
            end
            S16: begin
                Mem_WE_n = 1'b0;
                if (w_wait_done)
                    w_next = S18;
            end
            // LD_LED fires once here; the wait for Continue happens in PAUSE1
            S13: begin
                LD_LED = 1'b1;
                w_next = Continue ? PAUSE2 : PAUSE1;
            end
            PAUSE1: begin
                if (Continue)
                    w_next = PAUSE2;
            end
            PAUSE2: begin
                if (!Continue)
                    w_next = S18;
            end
            default: begin
                w_next = HALTED;
            end
        endcase
    end

endmodule
`default_nettype wire
